// File: rtl/weight_buffer_pkg.sv
// Shared accelerator parameters for the weight buffer and global controller.
// Holds data/address/count widths, the buffer depth and the almost-full
// threshold, plus count-width copies of the depth and threshold so that
// comparisons against the occupancy counter do not need width casts.
package weight_buffer_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 512;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned CNT_W  = 10;
    localparam int unsigned AF_TH  = 480;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_TH_CNT = CNT_W'(AF_TH);

endpackage

// File: rtl/weight_buffer_ram.sv
// Simple dual-port storage for the weight buffer.
// Ports:
//   clk            - clock, both ports on rising edge
//   we/waddr/wdata - write port
//   re/raddr       - synchronous read port request
//   rdata          - read data, updated only on an edge where re=1, otherwise held
// There is no reset: contents and rdata are undefined until written.
module weight_buffer_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [1 << ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/weight_buffer.sv
// Kernel weight FIFO between the PCIe write side and the conv/fc read side.
// Ports:
//   clk, rst         - clock and synchronous active-high reset
//   ena              - block enable; 0 freezes state (rdValid drops)
//   flush            - synchronous clear from global controller
//   wrEn, wrData     - write request and data
//   rdEn             - read request
//   rdData, rdValid  - registered read data and its one-cycle strobe
//   full, empty, almostFull, count - registered occupancy status
//   overflow, underflow            - sticky error flags
// A read accepted at edge N latches the RAM word at edge N and presents it
// on rdData/rdValid after edge N+1; the extra stage gives rdData a reset
// value even though the RAM has none.
module weight_buffer
    import weight_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              flush,
    input  logic              wrEn,
    input  logic [DATA_W-1:0] wrData,
    input  logic              rdEn,
    output logic [DATA_W-1:0] rdData,
    output logic              rdValid,
    output logic              full,
    output logic              empty,
    output logic              almostFull,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [DATA_W-1:0] ram_q;
    logic              rd_pend;
    logic              active;
    logic              wr_ok;
    logic              rd_ok;
    logic [CNT_W-1:0]  count_next;

    assign active = ena && !flush;
    assign wr_ok  = active && wrEn && !full;
    assign rd_ok  = active && rdEn && !empty;

    always_comb begin
        count_next = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    weight_buffer_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (wr_ok),
        .waddr(wr_ptr),
        .wdata(wrData),
        .re   (rd_ok),
        .raddr(rd_ptr),
        .rdata(ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            almostFull <= 1'b0;
            rd_pend    <= 1'b0;
            rdValid    <= 1'b0;
            rdData     <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (ena) begin
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                full       <= 1'b0;
                empty      <= 1'b1;
                almostFull <= 1'b0;
                rd_pend    <= 1'b0;
                rdValid    <= 1'b0;
                overflow   <= 1'b0;
                underflow  <= 1'b0;
            end else begin
                if (wr_ok) begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                end
                if (rd_ok) begin
                    rd_ptr <= rd_ptr + ADDR_W'(1);
                end
                count      <= count_next;
                full       <= (count_next == DEPTH_CNT);
                empty      <= (count_next == '0);
                almostFull <= (count_next >= AF_TH_CNT);
                overflow   <= overflow  || (wrEn && full);
                underflow  <= underflow || (rdEn && empty);
                rd_pend    <= rd_ok;
                rdValid    <= rd_pend;
                if (rd_pend) begin
                    rdData <= ram_q;
                end
            end
        end else begin
            // Disabled: everything holds; a pending read resumes once ena returns.
            rdValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_weight_buffer.sv
module tb_weight_buffer;
    import weight_buffer_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              ena;
    logic              flush;
    logic              wrEn;
    logic [DATA_W-1:0] wrData;
    logic              rdEn;
    logic [DATA_W-1:0] rdData;
    logic              rdValid;
    logic              full;
    logic              empty;
    logic              almostFull;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    weight_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .flush     (flush),
        .wrEn      (wrEn),
        .wrData    (wrData),
        .rdEn      (rdEn),
        .rdData    (rdData),
        .rdValid   (rdValid),
        .full      (full),
        .empty     (empty),
        .almostFull(almostFull),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cycle(input logic r, input logic e, input logic f,
                         input logic w, input logic [31:0] d, input logic rd);
        rst    = r;
        ena    = e;
        flush  = f;
        wrEn   = w;
        wrData = d;
        rdEn   = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(0, 1, 0, 0, 0, 0);
    endtask

    task automatic do_flush();
        cycle(0, 1, 1, 0, 0, 0);
    endtask

    task automatic write_n(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            cycle(0, 1, 0, 1, base + 32'(i), 0);
        end
    endtask

    // Issue n reads back to back, plus one idle cycle to collect the last word.
    task automatic read_n(input int n, input logic [31:0] base);
        for (int i = 0; i <= n; i++) begin
            cycle(0, 1, 0, 0, 0, i < n);
            if (i == 0) begin
                chk("rd_valid_first", rdValid, 0);
            end else begin
                chk("rd_valid", rdValid, 1);
                chk("rd_data", rdData, base + 32'(i - 1));
            end
        end
    endtask

    initial begin
        logic [CNT_W-1:0] cnt_snap;

        // Reset state
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_af", almostFull, 0);
        chk("rst_rdvalid", rdValid, 0);
        chk("rst_rddata", rdData, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);

        // Fill 0..511
        for (int k = 1; k <= 512; k++) begin
            cycle(0, 1, 0, 1, 32'(k - 1), 0);
            chk("fill_count", count, k);
            chk("fill_af", almostFull, k >= 480);
            chk("fill_full", full, k == 512);
            chk("fill_empty", empty, 0);
        end
        chk("fill_ovf_pre", overflow, 0);
        cycle(0, 1, 0, 1, 32'hDEAD, 0);
        chk("fill_ovf", overflow, 1);
        chk("fill_count_ovf", count, 512);
        chk("fill_full_ovf", full, 1);

        // Drain 0..511 in order
        read_n(512, 0);
        chk("drain_count", count, 0);
        chk("drain_empty", empty, 1);
        chk("drain_full", full, 0);
        chk("drain_af", almostFull, 0);
        chk("drain_udf_pre", underflow, 0);
        cycle(0, 1, 0, 0, 0, 1);
        chk("drain_udf", underflow, 1);
        chk("drain_udf_valid", rdValid, 0);
        chk("drain_hold_data", rdData, 511);
        idle();
        chk("drain_udf_valid2", rdValid, 0);
        chk("drain_udf_count", count, 0);

        // Wrap across address 511 -> 0
        do_flush();
        chk("flush_udf", underflow, 0);
        chk("flush_ovf", overflow, 0);
        write_n(400, 1000);
        chk("wrap_count400", count, 400);
        read_n(400, 1000);
        write_n(300, 5000);
        chk("wrap_count300", count, 300);
        read_n(300, 5000);
        chk("wrap_count_end", count, 0);
        chk("wrap_empty_end", empty, 1);

        // Simultaneous read+write at empty and at full
        do_flush();
        cycle(0, 1, 0, 1, 77, 1);
        chk("sim0_count", count, 1);
        chk("sim0_udf", underflow, 1);
        chk("sim0_empty", empty, 0);
        idle();
        chk("sim0_valid", rdValid, 0);
        write_n(511, 78);
        chk("sim_full_pre", full, 1);
        cycle(0, 1, 0, 1, 32'hBEEF, 1);
        chk("sim512_count", count, 511);
        chk("sim512_ovf", overflow, 1);
        chk("sim512_full", full, 0);
        idle();
        chk("sim512_valid", rdValid, 1);
        chk("sim512_data", rdData, 77);
        // Mid-range simultaneous: both complete, count unchanged
        cycle(0, 1, 0, 1, 9999, 1);
        chk("simmid_count", count, 511);
        idle();
        chk("simmid_data", rdData, 78);

        // Flush overrides a write
        do_flush();
        write_n(100, 0);
        chk("fl_count100", count, 100);
        cycle(0, 1, 1, 1, 123, 0);
        chk("fl_count", count, 0);
        chk("fl_empty", empty, 1);
        chk("fl_full", full, 0);
        chk("fl_af", almostFull, 0);
        chk("fl_ovf", overflow, 0);
        chk("fl_udf", underflow, 0);
        chk("fl_valid", rdValid, 0);

        // Enable low freezes state
        write_n(3, 500);
        cycle(0, 1, 0, 0, 0, 1);
        idle();
        chk("en_pre_data", rdData, 500);
        chk("en_pre_valid", rdValid, 1);
        cnt_snap = count;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 1, 1, 32'hFFFF, 1);
            chk("en_count", count, 2);
            chk("en_data", rdData, 500);
            chk("en_valid", rdValid, 0);
            chk("en_empty", empty, 0);
            chk("en_flags", {30'd0, overflow, underflow}, 0);
        end
        chk("en_count_snap", count, cnt_snap);
        read_n(2, 501);
        chk("en_after_count", count, 0);

        // Reset during continuous write+read
        do_flush();
        write_n(50, 2000);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 0, 1, 3000 + 32'(i), 1);
            chk("rs_stream_count", count, 50);
        end
        cycle(1, 1, 0, 1, 32'h1234, 1);
        chk("rs_count", count, 0);
        chk("rs_empty", empty, 1);
        chk("rs_full", full, 0);
        chk("rs_af", almostFull, 0);
        chk("rs_valid", rdValid, 0);
        chk("rs_data", rdData, 0);
        chk("rs_flags", {30'd0, overflow, underflow}, 0);
        write_n(2, 7000);
        read_n(2, 7000);
        chk("rs_after_count", count, 0);
        chk("rs_after_empty", empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/weight_buffer.md
WEIGHT_BUFFER -- requirements
Module: weight_buffer

Interface
REQ-001 The block SHALL have one clock, clk; reset is synchronous and active-high, port rst.
REQ-002 Ports SHALL be, in this order (name  direction  width  meaning):
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- ena  in  1  block enable; 0 freezes all state
- flush  in  1  synchronous clear from global controller (weightRst), active-high
- wrEn  in  1  PCIe-side write request
- wrData  in  32  kernel weight word from PCIe
- rdEn  in  1  conv/fc-side read request (weightReadEn)
- rdData  out  32  read data, registered
- rdValid  out  1  rdData updated this cycle
- full  out  1  occupancy == DEPTH (drives weightFull)
- empty  out  1  occupancy == 0 (drives weightEmpty)
- almostFull  out  1  occupancy >= AF_TH
- count  out  10  current occupancy, 0..512
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

Function
REQ-003 Storage SHALL be a FIFO, DEPTH=512 words of 32 bits, ADDR_W=9.
REQ-004 A write SHALL be accepted iff ena=1, flush=0, wrEn=1 and full=0; wrData is stored at wrPtr, wrPtr increments.
REQ-005 A read SHALL be accepted iff ena=1, flush=0, rdEn=1 and empty=0; rdPtr increments.
REQ-006 Read latency SHALL be 1 cycle: on an accepted read at edge N, rdData holds the word and rdValid=1 after edge N+1.
REQ-007 rdValid SHALL be 1 for exactly one cycle per accepted read; rdData SHALL hold its last value otherwise.
REQ-008 Pointers SHALL wrap 511 -> 0 with no gap; order SHALL be strictly first-in first-out.
REQ-009 count SHALL update the same edge as the accepted operation: +1 write only, -1 read only, unchanged if both or neither.
REQ-010 full, empty and almostFull SHALL be registered and consistent with count after each edge; AF_TH=480.
REQ-011 Write while full SHALL be rejected even if a read is accepted the same cycle, and SHALL set overflow.
REQ-012 Read while empty SHALL be rejected even if a write is accepted the same cycle, and SHALL set underflow; rdValid stays 0.
REQ-013 Simultaneous accepted read and write at 0<count<512 SHALL both complete; count unchanged.
REQ-014 flush=1 (with ena=1) SHALL clear pointers, count, rdValid, overflow and underflow, set empty=1, and override wrEn/rdEn that cycle; RAM contents need not be cleared.
REQ-015 ena=0 SHALL ignore wrEn, rdEn and flush, holding all registers including rdData; rdValid SHALL drop to 0.
REQ-016 overflow and underflow SHALL stay set until rst or flush.

Reset
REQ-017 rst=1 at a rising edge SHALL force count=0, pointers=0, empty=1, full=0, almostFull=0, rdValid=0, rdData=0, overflow=0, underflow=0, regardless of ena.
REQ-018 rst SHALL take priority over flush, wrEn and rdEn; reset mid-stream SHALL discard all stored words.

Structure
REQ-019 DATA_W=32, DEPTH=512, ADDR_W=9, CNT_W=10 and AF_TH=480 SHALL live in the shared accelerator parameter package/header used by global_controller.
REQ-020 Storage SHALL be one sub-module, weight_buffer_ram: simple dual-port, one write port, one synchronous read port, no reset.

Verification
REQ-021 Fill: after rst, 512 writes of 0..511 -> count=512, full=1, almostFull=1 from the 480th write, empty=0; 513th write sets overflow, count stays 512.
REQ-022 Drain: 512 reads after fill -> rdData 0..511 in order, each one cycle after its rdEn, rdValid one cycle each; empty=1 after the last; one extra read sets underflow, rdValid=0.
REQ-023 Wrap: write 400, read 400, write 300, read 300 -> data in order across address 511->0, count ends 0.
REQ-024 Simultaneous: at count=0, wrEn=rdEn=1 -> write accepted, read rejected, count=1, underflow=1; at count=512 -> read accepted, write rejected, count=511, overflow=1.
REQ-025 Flush/enable: count=100, flush with wrEn=1 -> count=0, empty=1, flags 0; with ena=0 apply wrEn, rdEn, flush for 5 cycles -> no state change.
REQ-026 Reset mid-operation: rst during continuous write+read at count=50 -> all outputs at reset values next edge; subsequent write/read returns only new data.
